add_pipe: RTL and testbench
===========================

Name: add_pipe

Overview:
- Parametrised, pipelined W-bit adder for the multiplier basic library; the multi-bit, registered successor of the single-bit half/full adder cells.
- Splits operands into CHUNK-bit slices and adds one slice per stage, registering the carry between stages, so the adder closes timing at any width.
- Used as the final carry-propagate adder behind partial-product reduction.
- Valid/ready handshakes on input and output, with a global stall.

Parameters:
- W, 16: operand and sum width in bits (W >= 1).
- CHUNK, 4: bits added per pipeline stage (1 <= CHUNK <= W).
- STAGES, derived as ceil(W/CHUNK): pipeline depth. It is a localparam, not overridable. The last slice is W-(STAGES-1)*CHUNK bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b (and sub) are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  W  operand A, unsigned.
- b  input  W  operand B, unsigned.
- out_valid  output  1  sum/cout hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  W  result bits [W-1:0].
- cout  output  1  carry out of bit W-1.
- sub  input  1  subtract select. Present only with ADD_PIPE_SUB_EN.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - While rst=1: every stage valid bit, all operand skew, partial-sum and carry registers, sum, cout and out_valid are 0.
  - in_ready is 0 while rst=1. After rst deasserts it is 1, because the pipeline is empty.
- Advance signal: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv=0 every pipeline register holds (global stall). This covers valid bits, operand skew, partial sums and carries.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - With adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stage k (0..STAGES-1), on adv:
  - Adds slice k of A, slice k of B and carry_in.
  - carry_in is 0 for stage 0 (the sub value in SUB mode). Otherwise it is the registered carry from stage k-1.
  - Registers the slice sum and carry_out.
  - Operand slices for later stages travel in delay registers so they meet their carry.
  - Finished lower slices travel in delay registers so all slices emerge together.
- Last stage registers are sum/cout directly. There is no extra output register.
- Latency:
  - An operand pair accepted at edge n is presented with out_valid=1 after edge n+STAGES-1, i.e. in the cycle following it.
  - This assumes no stall. Each stall cycle adds one cycle.
  - STAGES=1 gives out_valid in the cycle after acceptance.
- Throughput: one result per cycle when out_ready=1. Order is preserved and no result is dropped or duplicated.
- Arithmetic:
  - {cout,sum} = a + b, computed modulo 2^(W+1). This is exact.
  - A carry out of a non-final slice feeds only the next stage. It is never visible on cout.
- Boundary conditions:
  - All-ones plus one: the carry ripples through every stage, giving sum=0, cout=1.
  - Full pipeline with out_ready=0 holds STAGES results. in_ready=0 until out_ready rises.
  - Simultaneous input and output transfer in the same cycle is allowed. Occupancy is unchanged.
  - Reset mid-operation discards all in-flight results. No partial result appears after reset.
  - sum/cout may hold stale data when out_valid=0. The bench ignores them then.

Optional Feature:
- Macro ADD_PIPE_SUB_EN.
- Defined:
  - Port sub exists. It is sampled with its operands and travels down the pipeline in a 1-bit delay line.
  - sub=1: each stage uses ~b slice, and stage 0 carry_in=1. So {cout,sum} = a + ~b + 1.
  - cout=1 means no borrow (a >= b).
  - sub=0 behaves exactly as the add-only build.
- Undefined: no sub port and no delay line. Stage 0 carry_in is tied to 0, and B is never inverted.

Test Plan:
1. W=16, CHUNK=4, a=0xFFFF, b=0x0001, out_ready=1:
   - out_valid rises 4 cycles after acceptance with sum=0x0000, cout=1.
   - out_valid falls the next cycle if nothing else was sent.
2. Stream of 8 pairs back-to-back (a=i*0x1111, b=0x0F0F), out_ready=1:
   - in_ready stays 1, and one result per cycle arrives in order.
   - Each result is {cout,sum}=a+b. Checked against a reference model.
3. Fill the pipeline with 4 pairs, then hold out_ready=0 for 6 cycles:
   - in_ready=0 and sum/cout/out_valid stay frozen.
   - After out_ready=1, all 4 results emerge in order with none lost.
4. rst pulsed for 1 cycle with 3 results in flight:
   - out_valid=0 and sum=0, cout=0 immediately, without waiting for a clock edge.
   - No stale result ever appears after reset.
5. W=16, CHUNK=5 (STAGES=4, last slice 1 bit), a=0x8000, b=0x8000: sum=0x0000, cout=1 after 4 cycles.
6. ADD_PIPE_SUB_EN defined:
   - a=0x0005, b=0x0007, sub=1 gives sum=0xFFFE, cout=0.
   - The next beat a=0x0007, b=0x0005, sub=1 gives sum=0x0002, cout=1.

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined W-bit carry-propagate adder, one CHUNK-bit slice per stage,
// valid/ready handshake with global stall. Define ADD_PIPE_SUB_EN to add the sub port.
module add_pipe #(
  parameter int unsigned W     = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef ADD_PIPE_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned STAGES = (W + CHUNK - 1) / CHUNK;
  localparam int unsigned LAST   = W - (STAGES - 1) * CHUNK;

  logic adv;

  // One shared advance: the whole pipe moves or the whole pipe holds.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO  = k * CHUNK;
    localparam int unsigned SW  = (k == STAGES - 1) ? LAST : CHUNK;
    localparam int unsigned SW1 = SW + 1;
    localparam int unsigned RW  = W - LO;

    logic [RW-1:0]    a_in;
    logic [RW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [SW-1:0]    b_eff;
    logic [SW:0]      slice;
    logic [LO+SW-1:0] ps_nxt;
    logic             v_q;
    logic             c_q;
    logic [LO+SW-1:0] ps_q;
`ifdef ADD_PIPE_SUB_EN
    logic             s_in;
`endif

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b;
      assign v_in   = in_valid;
      assign ps_nxt = slice[SW-1:0];
`ifdef ADD_PIPE_SUB_EN
      assign s_in   = sub;
      assign c_in   = sub;
`else
      assign c_in   = 1'b0;
`endif
    end else begin : g_body
      assign a_in   = g_stg[k-1].g_skew.a_q;
      assign b_in   = g_stg[k-1].g_skew.b_q;
      assign v_in   = g_stg[k-1].v_q;
      assign c_in   = g_stg[k-1].c_q;
      assign ps_nxt = {slice[SW-1:0], g_stg[k-1].ps_q};
`ifdef ADD_PIPE_SUB_EN
      assign s_in   = g_stg[k-1].g_skew.s_q;
`endif
    end

`ifdef ADD_PIPE_SUB_EN
    assign b_eff = b_in[SW-1:0] ^ {SW{s_in}};
`else
    assign b_eff = b_in[SW-1:0];
`endif

    assign slice = SW1'(a_in[SW-1:0]) + SW1'(b_eff) + SW1'(c_in);

    // Slice result, carry and valid for this stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        ps_q <= '0;
      end else if (adv) begin
        v_q  <= v_in;
        c_q  <= slice[SW];
        ps_q <= ps_nxt;
      end
    end

    // Upper operand bits wait here until their carry arrives.
    if (k < STAGES - 1) begin : g_skew
      logic [RW-SW-1:0] a_q;
      logic [RW-SW-1:0] b_q;
`ifdef ADD_PIPE_SUB_EN
      logic             s_q;
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
`ifdef ADD_PIPE_SUB_EN
          s_q <= 1'b0;
`endif
        end else if (adv) begin
          a_q <= a_in[RW-1:SW];
          b_q <= b_in[RW-1:SW];
`ifdef ADD_PIPE_SUB_EN
          s_q <= s_in;
`endif
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].ps_q;
  assign cout      = g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed tests for add_pipe (CHUNK=4 and CHUNK=5 builds, optional subtract).
module tb_add_pipe;
  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, cout1;
  logic [W-1:0] a1, b1, sum1;
`ifdef ADD_PIPE_SUB_EN
  logic         sub;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [W:0] EXP_B2B [8] = '{17'h00F0F, 17'h02020, 17'h03131, 17'h04242,
                                         17'h05353, 17'h06464, 17'h07575, 17'h08686};

  add_pipe #(.W(W), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef ADD_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  add_pipe #(.W(W), .CHUNK(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
`ifdef ADD_PIPE_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({out_valid, cout, sum, in_ready} !== 19'h0) begin
      $display("FAIL reset_state: got v=%b c=%b s=%h rdy=%b, expected all 0", out_valid, cout, sum, in_ready);
    end else pass_cnt++;
    step();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", in_ready, out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_carry_ripple;
    out_ready = 1'b1;
    a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL ripple_early: got v=%b, expected 0", out_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || {cout, sum} !== 17'h10000)
      $display("FAIL ripple_result: got v=%b %h, expected v=1 10000", out_valid, {cout, sum});
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL ripple_drop: got v=%b, expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int idx = 0;
    int first_c = -1;
    int last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (acc < 8) begin
        in_valid = 1'b1;
        a = W'(acc * 16'h1111);
        b = 16'h0F0F;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready: beat %0d got %b, expected 1", acc, in_ready);
        else pass_cnt++;
        if (in_ready) acc++;
      end else in_valid = 1'b0;
      step();
      if (out_valid) begin
        total_cnt++;
        if (idx >= 8 || {cout, sum} !== EXP_B2B[idx])
          $display("FAIL b2b_result: idx %0d got %h", idx, {cout, sum});
        else pass_cnt++;
        if (first_c < 0) first_c = c;
        last_c = c;
        idx++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (idx != 8 || last_c - first_c != 7)
      $display("FAIL b2b_count: got %0d results over %0d cycles, expected 8 over 8", idx, last_c - first_c + 1);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    logic [W:0]   ex [4];
    int idx = 0;
    sa = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F};
    sb = '{16'h1111, 16'hFFFF, 16'h7FFF, 16'hF0F1};
    ex = '{17'h02345, 17'h1FFFE, 17'h0FFFF, 17'h10000};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = sa[i]; b = sb[i];
      step();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL stall_full: got rdy=%b v=%b, expected rdy=0 v=1", in_ready, out_valid);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, sum} !== ex[0])
        $display("FAIL stall_hold: cycle %0d got rdy=%b v=%b %h, expected rdy=0 v=1 %h",
                 i, in_ready, out_valid, {cout, sum}, ex[0]);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        total_cnt++;
        if (idx >= 4 || {cout, sum} !== ex[idx])
          $display("FAIL stall_drain: idx %0d got %h", idx, {cout, sum});
        else pass_cnt++;
        idx++;
      end
      step();
    end
    total_cnt++;
    if (idx != 4) $display("FAIL stall_count: got %0d results, expected 4", idx);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight;
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'(16'h0101 * (i + 1)); b = 16'h2222;
      step();
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || {cout, sum} !== 17'h02323)
      $display("FAIL midrst_pre: got v=%b %h, expected v=1 02323", out_valid, {cout, sum});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || {cout, sum} !== 17'h0 || in_ready !== 1'b0)
      $display("FAIL midrst_async: got v=%b %h rdy=%b, expected v=0 00000 rdy=0",
               out_valid, {cout, sum}, in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b, expected 1", in_ready);
    else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    total_cnt++;
    if (stale != 0) $display("FAIL midrst_stale: got %0d valid cycles, expected 0", stale);
    else pass_cnt++;
  endtask

  task automatic test_chunk5;
    out_ready1 = 1'b1;
    total_cnt++;
    if (in_ready1 !== 1'b1) $display("FAIL c5_ready: got %b, expected 1", in_ready1);
    else pass_cnt++;
    in_valid1 = 1'b1; a1 = 16'h8000; b1 = 16'h8000;
    step();
    a1 = 16'h7FFF; b1 = 16'h0001;
    step();
    in_valid1 = 1'b0;
    step();
    total_cnt++;
    if (out_valid1 !== 1'b0) $display("FAIL c5_early: got v=%b, expected 0", out_valid1);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid1 !== 1'b1 || {cout1, sum1} !== 17'h10000)
      $display("FAIL c5_msb: got v=%b %h, expected v=1 10000", out_valid1, {cout1, sum1});
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid1 !== 1'b1 || {cout1, sum1} !== 17'h08000)
      $display("FAIL c5_ripple: got v=%b %h, expected v=1 08000", out_valid1, {cout1, sum1});
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid1 !== 1'b0) $display("FAIL c5_drop: got v=%b, expected 0", out_valid1);
    else pass_cnt++;
  endtask

`ifdef ADD_PIPE_SUB_EN
  task automatic test_sub;
    out_ready = 1'b1;
    in_valid = 1'b1; sub = 1'b1; a = 16'h0005; b = 16'h0007;
    step();
    a = 16'h0007; b = 16'h0005;
    step();
    in_valid = 1'b0; sub = 1'b0;
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || {cout, sum} !== 17'h0FFFE)
      $display("FAIL sub_borrow: got v=%b %h, expected v=1 0FFFE", out_valid, {cout, sum});
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || {cout, sum} !== 17'h10002)
      $display("FAIL sub_noborrow: got v=%b %h, expected v=1 10002", out_valid, {cout, sum});
    else pass_cnt++;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
`ifdef ADD_PIPE_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_carry_ripple();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_chunk5();
`ifdef ADD_PIPE_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
